pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised fetch program-counter unit. Successor to the single-register PC.
- Holds the current fetch address and advances it by 4 each cycle.
- Supports stall, branch/jump redirect, trap vectoring, and a small return-address stack (RAS) for predicted returns.
- Sits between the fetch stage (consumes pc/pc_valid) and decode/execute (supply redirect, trap and call/return hints).

Parameters:
- XLEN, 32, address width in bits.
- RESET_VECTOR, 0, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, address loaded on trap or misaligned redirect.
- RAS_DEPTH, 4, number of RAS entries (power of two, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold pc (sequential/RAS advance suppressed).
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  XLEN  redirect target.
- trap_valid  in  1  exception; load TRAP_VECTOR.
- ras_push  in  1  call seen; push ras_push_addr.
- ras_push_addr  in  XLEN  return address to push.
- ras_pop  in  1  predicted return; next pc = RAS top.
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is a valid fetch address.
- misalign_err  out  1  one-cycle pulse: redirect target misaligned.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_VECTOR, pc_valid=0, misalign_err=0.
  - RAS count=0 and top pointer=0, so ras_empty=1 and ras_full=0.
  - Reset mid-operation discards everything in flight.
- First edge with rst=0: pc_valid<=1, pc unchanged (first fetch = RESET_VECTOR). pc_valid then stays 1 until the next reset.
- Subsequent edges use a priority update; first match wins:
  1. trap_valid:
     - pc<=TRAP_VECTOR; RAS cleared (count=0).
     - Push/pop ignored.
  2. redirect_valid with redirect_pc[1:0]!=0:
     - pc<=TRAP_VECTOR; misalign_err<=1 for exactly one cycle; RAS cleared.
  3. redirect_valid (aligned):
     - pc<=redirect_pc; ras_pop ignored.
     - ras_push honoured (call-by-jump).
  4. stall: pc held; ras_push/ras_pop ignored.
  5. ras_pop and RAS non-empty:
     - pc<=RAS top; count decrements.
     - If ras_push is also high: the top entry is replaced by ras_push_addr and count is unchanged.
  6. Otherwise:
     - pc<=pc+4, modulo 2^XLEN (0xFFFFFFFC wraps to 0).
     - If ras_push: push.
- ras_pop on an empty RAS: treated as case 6 (sequential). Count stays 0; no error.
- Push when full:
  - Overwrites the oldest entry (circular pointer wrap); count saturates at RAS_DEPTH.
  - A subsequent pop sequence returns the RAS_DEPTH most recent addresses only.
- Push/pop use a top pointer modulo RAS_DEPTH:
  - Push: pointer++ then write.
  - Pop: read then pointer--.
- RAS contents are not reset; only count and pointer are. No read of an invalid entry is possible.
- misalign_err is 0 on every edge not in case 2.
- Stall never blocks trap or redirect.
- All outputs are registered or derived from registers only (no input-to-output combinational path). Latency from any control input to pc = 1 cycle.

Test Plan:
- Reset and run: hold rst 3 cycles, release, no other inputs.
  - Required: pc = 0, 0, 4, 8, 12 on successive cycles.
  - Required: pc_valid 0 during reset, 1 from the first post-reset edge.
- Stall/redirect priority: at pc=0x10 assert stall 2 cycles, then stall and redirect_valid with redirect_pc=0x200.
  - Required: pc holds 0x10 for 2 cycles, then 0x200, then 0x204 once stall drops.
- Misaligned redirect: redirect_pc=0x202.
  - Required: pc=0x100, misalign_err high exactly 1 cycle, ras_empty=1.
- RAS call/return: push 0x40, push 0x80, then ras_pop twice, then ras_pop on empty.
  - Required: pc = 0x80, then 0x40, then previous pc+4.
  - Required: ras_empty asserts after the second pop.
- RAS overflow (RAS_DEPTH=4): push 0x10, 0x20, 0x30, 0x40, 0x50, then 5 pops.
  - Required: ras_full=1 after the 4th push.
  - Required: pops return 0x50, 0x40, 0x30, 0x20, then sequential pc+4.
- Wrap and trap: force pc to 0xFFFFFFFC via redirect.
  - Required: next pc=0x0.
  - Then assert trap_valid together with ras_pop on a non-empty RAS. Required: pc=0x100, RAS count=0, no pop taken.
  - Then assert rst mid-stream. Required: pc=0, pc_valid=0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with stall, redirect, trap vectoring and a
// circular return-address stack for predicted returns.
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'('h100),
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic            ras_empty,
  output logic            ras_full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]   top, top_next, wr_ptr;
  logic [CW-1:0]   count, count_next;
  logic [XLEN-1:0] pc_next;
  logic            mis_next, do_push, wr_en;
  assign ras_empty = count == '0;
  assign ras_full  = count == CW'(RAS_DEPTH);
  always_comb begin
    pc_next    = pc;
    top_next   = top;
    count_next = count;
    mis_next   = 1'b0;
    do_push    = 1'b0;
    wr_en      = 1'b0;
    wr_ptr     = top;
    if (!pc_valid) begin
      pc_next = pc;
    end else if (trap_valid) begin
      pc_next    = TRAP_VECTOR;
      count_next = '0;
    end else if (redirect_valid && |redirect_pc[1:0]) begin
      pc_next    = TRAP_VECTOR;
      mis_next   = 1'b1;
      count_next = '0;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
      do_push = ras_push;
    end else if (stall) begin
      pc_next = pc;
    end else if (ras_pop && !ras_empty) begin
      pc_next = stack[top];
      // pop+push in one cycle swaps the top entry in place
      if (ras_push) begin
        wr_en = 1'b1;
      end else begin
        top_next   = top - 1'b1;
        count_next = count - 1'b1;
      end
    end else begin
      pc_next = pc + XLEN'(4);
      do_push = ras_push;
    end
    if (do_push) begin
      top_next   = top + 1'b1;
      wr_ptr     = top + 1'b1;
      wr_en      = 1'b1;
      count_next = ras_full ? count : count + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
      top          <= '0;
      count        <= '0;
    end else begin
      pc           <= pc_next;
      pc_valid     <= 1'b1;
      misalign_err <= mis_next;
      top          <= top_next;
      count        <= count_next;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_en) stack[wr_ptr] <= ras_push_addr;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with hand-computed expectations for pc_unit.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap_valid = 1'b0;
  logic        ras_push = 1'b0;
  logic [31:0] ras_push_addr = '0;
  logic        ras_pop = 1'b0;
  logic [31:0] pc;
  logic        pc_valid, misalign_err, ras_empty, ras_full;
  int          n_vec = 0;
  int          n_bad = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .ras_push(ras_push),
    .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc(pc), .pc_valid(pc_valid), .misalign_err(misalign_err),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_pc(input string tag, input logic [31:0] exp);
    step();
    check(tag, pc, exp);
  endtask

  task automatic push_step(input logic [31:0] a, input logic [31:0] exp);
    ras_push = 1'b1;
    ras_push_addr = a;
    step_pc("push_pc", exp);
    ras_push = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'b0, pc_valid}, 32'h0);
    end
    check("rst_empty", {31'b0, ras_empty}, 32'h1);
    check("rst_full", {31'b0, ras_full}, 32'h0);
    rst = 1'b0;
    step_pc("run0", 32'h0);
    check("run_valid", {31'b0, pc_valid}, 32'h1);
    step_pc("run1", 32'h4);
    step_pc("run2", 32'h8);
    step_pc("run3", 32'hC);
    step_pc("run4", 32'h10);
    stall = 1'b1;
    step_pc("stall0", 32'h10);
    step_pc("stall1", 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step_pc("stall_redir", 32'h200);
    stall = 1'b0;
    redirect_valid = 1'b0;
    step_pc("after_redir", 32'h204);
    redirect_valid = 1'b1;
    redirect_pc = 32'h202;
    step_pc("misalign_pc", 32'h100);
    check("misalign_err", {31'b0, misalign_err}, 32'h1);
    check("misalign_empty", {31'b0, ras_empty}, 32'h1);
    redirect_valid = 1'b0;
    step_pc("post_mis_pc", 32'h104);
    check("misalign_clr", {31'b0, misalign_err}, 32'h0);
    push_step(32'h40, 32'h108);
    check("push_nonempty", {31'b0, ras_empty}, 32'h0);
    push_step(32'h80, 32'h10C);
    ras_pop = 1'b1;
    step_pc("ret0", 32'h80);
    check("ret0_empty", {31'b0, ras_empty}, 32'h0);
    step_pc("ret1", 32'h40);
    check("ret1_empty", {31'b0, ras_empty}, 32'h1);
    step_pc("pop_empty", 32'h44);
    ras_pop = 1'b0;
    push_step(32'h10, 32'h48);
    push_step(32'h20, 32'h4C);
    push_step(32'h30, 32'h50);
    check("not_full3", {31'b0, ras_full}, 32'h0);
    push_step(32'h40, 32'h54);
    check("full4", {31'b0, ras_full}, 32'h1);
    push_step(32'h50, 32'h58);
    check("full5", {31'b0, ras_full}, 32'h1);
    ras_pop = 1'b1;
    step_pc("ovf_pop0", 32'h50);
    check("ovf_notfull", {31'b0, ras_full}, 32'h0);
    step_pc("ovf_pop1", 32'h40);
    step_pc("ovf_pop2", 32'h30);
    step_pc("ovf_pop3", 32'h20);
    check("ovf_empty", {31'b0, ras_empty}, 32'h1);
    step_pc("ovf_pop4", 32'h24);
    ras_pop = 1'b0;
    push_step(32'hA0, 32'h28);
    ras_pop = 1'b1;
    ras_push = 1'b1;
    ras_push_addr = 32'hB0;
    step_pc("swap_pc", 32'hA0);
    check("swap_count", {31'b0, ras_empty}, 32'h0);
    ras_push = 1'b0;
    step_pc("swap_pop", 32'hB0);
    check("swap_empty", {31'b0, ras_empty}, 32'h1);
    ras_pop = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step_pc("wrap_redir", 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step_pc("wrap_zero", 32'h0);
    push_step(32'h300, 32'h4);
    trap_valid = 1'b1;
    ras_pop = 1'b1;
    step_pc("trap_pc", 32'h100);
    check("trap_empty", {31'b0, ras_empty}, 32'h1);
    check("trap_nomis", {31'b0, misalign_err}, 32'h0);
    trap_valid = 1'b0;
    step_pc("post_trap", 32'h104);
    ras_pop = 1'b0;
    step_pc("pre_rst", 32'h108);
    rst = 1'b1;
    step_pc("mid_rst_pc", 32'h0);
    check("mid_rst_valid", {31'b0, pc_valid}, 32'h0);
    check("mid_rst_empty", {31'b0, ras_empty}, 32'h1);
    rst = 1'b0;
    step_pc("rerun0", 32'h0);
    step_pc("rerun1", 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
